// File: rtl/lce_ctrl_pkg.sv
// Shared types and defaults for the LCE selection sweep controller.
package lce_ctrl_pkg;

  localparam int LCE_NBIT_AP       = 4;
  localparam int LCE_NBIT_CM       = 2;
  localparam int LCE_RST_CYCLES    = 16;
  localparam int LCE_WINDOW_CYCLES = 1024;
  localparam int LCE_CNT_W         = $clog2(LCE_WINDOW_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_REPORT,
    S_NEXT,
    S_DONE
  } lce_state_t;

  // One result record per (access point, compare mode) pair at the default widths.
  typedef struct packed {
    logic [LCE_NBIT_AP-1:0] ap;
    logic [LCE_NBIT_CM-1:0] cm;
    logic                   alarm;
    logic [LCE_CNT_W-1:0]   cycles;
  } lce_res_t;

  function automatic int lce_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lce_window_timer.sv
// Loadable up-counter with clear, enable and terminal-count flag; shared by the
// reset-hold and observation-window phases of the sweep.
module lce_window_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/lce_sweep_ctrl.sv
// Sweeps every (access point, compare mode) pair: holds the core in reset, watches
// alarm_i for a bounded window, and hands one result record per pair downstream.
module lce_sweep_ctrl
  import lce_ctrl_pkg::*;
#(
  parameter int NBIT_AP       = LCE_NBIT_AP,
  parameter int NBIT_CM       = LCE_NBIT_CM,
  parameter int AP_LAST       = 15,
  parameter int CM_LAST       = 3,
  parameter int RST_CYCLES    = LCE_RST_CYCLES,
  parameter int WINDOW_CYCLES = LCE_WINDOW_CYCLES,
  parameter int CNT_W         = $clog2(WINDOW_CYCLES + 1)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               alarm_i,
  output logic [NBIT_AP-1:0] ap_o,
  output logic [NBIT_CM-1:0] cm_o,
  output logic               rst_core_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [NBIT_AP-1:0] res_ap_o,
  output logic [NBIT_CM-1:0] res_cm_o,
  output logic               res_alarm_o,
  output logic [CNT_W-1:0]   res_cycles_o
);

  localparam int TMR_W = $clog2(lce_max(RST_CYCLES, WINDOW_CYCLES) + 1);

  lce_state_t       state;
  logic             tmr_clear;
  logic             tmr_load;
  logic             tmr_en;
  logic [TMR_W-1:0] tmr_term;
  logic [TMR_W-1:0] tmr_count;
  logic             tmr_tc;
  logic             last_pair;

  assign last_pair = (ap_o == NBIT_AP'(AP_LAST)) && (cm_o == NBIT_CM'(CM_LAST));

  // The timer is loaded with 1 on entry to HOLD and RUN so its value is the 1-based
  // cycle index within the phase; terminal count ends the phase.
  always_comb begin
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_term  = (state == S_HOLD) ? TMR_W'(RST_CYCLES) : TMR_W'(WINDOW_CYCLES);
    if (abort_i) begin
      tmr_clear = 1'b1;
    end else begin
      unique case (state)
        S_IDLE:  tmr_load = start_i;
        S_HOLD:  begin
          tmr_load = tmr_tc;
          tmr_en   = !tmr_tc;
        end
        S_RUN:   tmr_en = !tmr_tc;
        S_NEXT:  tmr_load = !last_pair;
        default: ;
      endcase
    end
  end

  lce_window_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk_i),
    .rst_n    (rstn_i),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (TMR_W'(1)),
    .en       (tmr_en),
    .term     (tmr_term),
    .count    (tmr_count),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= S_IDLE;
      ap_o         <= '0;
      cm_o         <= '0;
      rst_core_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      res_valid_o  <= 1'b0;
      res_ap_o     <= '0;
      res_cm_o     <= '0;
      res_alarm_o  <= 1'b0;
      res_cycles_o <= '0;
    end else if (abort_i) begin
      state       <= S_IDLE;
      rst_core_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      res_valid_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            ap_o       <= '0;
            cm_o       <= '0;
            rst_core_o <= 1'b1;
            busy_o     <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (tmr_tc) begin
            rst_core_o <= 1'b0;
            state      <= S_RUN;
          end
        end
        // An alarm on the final window cycle still reports alarm=1.
        S_RUN: begin
          if (alarm_i || tmr_tc) begin
            res_ap_o     <= ap_o;
            res_cm_o     <= cm_o;
            res_alarm_o  <= alarm_i;
            res_cycles_o <= tmr_count[CNT_W-1:0];
            res_valid_o  <= 1'b1;
            rst_core_o   <= 1'b1;
            state        <= S_REPORT;
          end
        end
        // Reset drops for the NEXT cycle so each HOLD is a clean RST_CYCLES pulse.
        S_REPORT: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            rst_core_o  <= 1'b0;
            state       <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (last_pair) begin
            done_o <= 1'b1;
            state  <= S_DONE;
          end else begin
            if (cm_o == NBIT_CM'(CM_LAST)) begin
              cm_o <= '0;
              ap_o <= ap_o + NBIT_AP'(1);
            end else begin
              cm_o <= cm_o + NBIT_CM'(1);
            end
            rst_core_o <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lce_sweep_ctrl.sv
// Directed bench for lce_sweep_ctrl on a reduced 2x2 sweep with short hold and window.
module tb_lce_sweep_ctrl;
  import lce_ctrl_pkg::*;

  localparam int NBIT_AP       = 4;
  localparam int NBIT_CM       = 2;
  localparam int AP_LAST       = 1;
  localparam int CM_LAST       = 1;
  localparam int RST_CYCLES    = 4;
  localparam int WINDOW_CYCLES = 8;
  localparam int CNT_W         = $clog2(WINDOW_CYCLES + 1);
  localparam int BUDGET        = 200;

  typedef struct {
    int       alarm_at;
    lce_res_t exp;
  } vec_t;

  logic               clk_i = 1'b0;
  logic               rstn_i = 1'b0;
  logic               start_i = 1'b0;
  logic               abort_i = 1'b0;
  logic               alarm_i = 1'b0;
  logic               res_ready_i = 1'b0;
  logic [NBIT_AP-1:0] ap_o;
  logic [NBIT_CM-1:0] cm_o;
  logic               rst_core_o;
  logic               busy_o;
  logic               done_o;
  logic               res_valid_o;
  logic [NBIT_AP-1:0] res_ap_o;
  logic [NBIT_CM-1:0] res_cm_o;
  logic               res_alarm_o;
  logic [CNT_W-1:0]   res_cycles_o;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   hold_len = 0;
  vec_t vecs[12];

  lce_sweep_ctrl #(
    .NBIT_AP      (NBIT_AP),
    .NBIT_CM      (NBIT_CM),
    .AP_LAST      (AP_LAST),
    .CM_LAST      (CM_LAST),
    .RST_CYCLES   (RST_CYCLES),
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .alarm_i     (alarm_i),
    .ap_o        (ap_o),
    .cm_o        (cm_o),
    .rst_core_o  (rst_core_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_ap_o    (res_ap_o),
    .res_cm_o    (res_cm_o),
    .res_alarm_o (res_alarm_o),
    .res_cycles_o(res_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out after %0d cycles", name, BUDGET);
  endtask

  // Each core-reset pulse outside REPORT must last exactly RST_CYCLES; done pulses are tallied.
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      hold_len = 0;
    end else begin
      if (done_o) done_cnt++;
      if (rst_core_o && !res_valid_o) begin
        hold_len++;
      end else begin
        if (hold_len != 0) checkOutput("hold_len", hold_len, RST_CYCLES);
        hold_len = 0;
      end
    end
  end

  function automatic vec_t mkVec(input int at, input int ap, input int cm, input int al, input int cyc);
    vec_t v;
    v.alarm_at   = at;
    v.exp.ap     = LCE_NBIT_AP'(ap);
    v.exp.cm     = LCE_NBIT_CM'(cm);
    v.exp.alarm  = 1'(al);
    v.exp.cycles = LCE_CNT_W'(cyc);
    return v;
  endfunction

  task automatic waitHold(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!(rst_core_o && !res_valid_o)) begin
      @(negedge clk_i);
      n++;
      if (n > BUDGET) begin ok = 1'b0; return; end
    end
  endtask

  task automatic waitRun(output bit ok);
    int n = 0;
    waitHold(ok);
    if (!ok) return;
    while (rst_core_o) begin
      @(negedge clk_i);
      n++;
      if (n > BUDGET) begin ok = 1'b0; return; end
    end
  endtask

  task automatic waitValid(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!res_valid_o) begin
      @(negedge clk_i);
      n++;
      if (n > BUDGET) begin ok = 1'b0; return; end
    end
  endtask

  task automatic checkRecord(input int idx);
    checkOutput($sformatf("rec%0d_ap", idx), res_ap_o, vecs[idx].exp.ap);
    checkOutput($sformatf("rec%0d_cm", idx), res_cm_o, vecs[idx].exp.cm);
    checkOutput($sformatf("rec%0d_alarm", idx), res_alarm_o, vecs[idx].exp.alarm);
    checkOutput($sformatf("rec%0d_cycles", idx), res_cycles_o, vecs[idx].exp.cycles);
  endtask

  // Drives one pair: waits for its window, pulses alarm on the requested RUN cycle, checks the record.
  task automatic applyStimulus(input int idx);
    bit ok;
    waitRun(ok);
    if (!ok) begin timeoutFail($sformatf("rec%0d_wait_run", idx)); return; end
    checkOutput($sformatf("rec%0d_sel_ap", idx), ap_o, vecs[idx].exp.ap);
    checkOutput($sformatf("rec%0d_sel_cm", idx), cm_o, vecs[idx].exp.cm);
    if (vecs[idx].alarm_at > 0) begin
      repeat (vecs[idx].alarm_at - 1) @(negedge clk_i);
      alarm_i = 1'b1;
      @(negedge clk_i);
      alarm_i = 1'b0;
    end
    waitValid(ok);
    if (!ok) begin timeoutFail($sformatf("rec%0d_wait_valid", idx)); return; end
    checkRecord(idx);
  endtask

  task automatic pulseStart();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic runSweep(input int first, input int n);
    int d0 = done_cnt;
    res_ready_i = 1'b1;
    pulseStart();
    for (int i = first; i < first + n; i++) applyStimulus(i);
    repeat (4) @(negedge clk_i);
    checkOutput("done_pulses", done_cnt - d0, 1);
    checkOutput("busy_after_done", busy_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int d0;
    logic [31:0] stall_exp;

    vecs[0]  = mkVec(0, 0, 0, 0, 8);
    vecs[1]  = mkVec(0, 0, 1, 0, 8);
    vecs[2]  = mkVec(0, 1, 0, 0, 8);
    vecs[3]  = mkVec(0, 1, 1, 0, 8);
    vecs[4]  = mkVec(0, 0, 0, 0, 8);
    vecs[5]  = mkVec(3, 0, 1, 1, 3);
    vecs[6]  = mkVec(0, 1, 0, 0, 8);
    vecs[7]  = mkVec(0, 1, 1, 0, 8);
    vecs[8]  = mkVec(0, 0, 0, 0, 8);
    vecs[9]  = mkVec(1, 0, 1, 1, 1);
    vecs[10] = mkVec(0, 1, 0, 0, 8);
    vecs[11] = mkVec(8, 1, 1, 1, 8);

    repeat (3) @(negedge clk_i);
    checkOutput("reset_outputs",
                {ap_o, cm_o, rst_core_o, busy_o, done_o, res_valid_o,
                 res_ap_o, res_cm_o, res_alarm_o, res_cycles_o}, 0);
    #2 rstn_i = 1'b1;

    $display("[TB] sweep without alarms");
    runSweep(0, 4);
    $display("[TB] sweep with alarm on RUN cycle 3 of (0,1)");
    runSweep(4, 4);

    $display("[TB] backpressure then abort");
    res_ready_i = 1'b0;
    d0 = done_cnt;
    pulseStart();
    waitRun(ok);
    if (!ok) timeoutFail("bp_wait_run");
    waitValid(ok);
    if (!ok) timeoutFail("bp_wait_valid");
    stall_exp = {1'b1, 4'd0, 2'd0, 1'b0, 4'd8, 1'b1, 4'd0, 2'd0};
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("stall_cycle%0d", c),
                  {res_valid_o, res_ap_o, res_cm_o, res_alarm_o, res_cycles_o,
                   rst_core_o, ap_o, cm_o}, stall_exp);
      @(negedge clk_i);
    end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("valid_after_handshake", res_valid_o, 1'b0);
    applyStimulus(1);
    waitRun(ok);
    if (!ok) timeoutFail("abort_wait_run");
    checkOutput("abort_pair_sel", {ap_o, cm_o}, {4'd1, 2'd0});
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    checkOutput("after_abort", {res_valid_o, rst_core_o, busy_o, done_o, ap_o, cm_o},
                {1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 2'd0});
    repeat (12) @(negedge clk_i);
    checkOutput("abort_no_done", done_cnt - d0, 0);
    checkOutput("abort_no_record", {res_valid_o, busy_o}, 0);

    $display("[TB] restart while busy then reset in HOLD");
    pulseStart();
    waitRun(ok);
    if (!ok) timeoutFail("rs_wait_run");
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    checkOutput("start_ignored", {rst_core_o, busy_o, ap_o, cm_o}, {1'b0, 1'b1, 4'd0, 2'd0});
    waitValid(ok);
    if (!ok) timeoutFail("rs_wait_valid");
    checkRecord(0);
    waitHold(ok);
    if (!ok) timeoutFail("rs_wait_hold");
    @(negedge clk_i);
    checkOutput("hold_sel_01", {rst_core_o, ap_o, cm_o}, {1'b1, 4'd0, 2'd1});
    #2 rstn_i = 1'b0;
    #1;
    checkOutput("reset_mid_sweep",
                {ap_o, cm_o, rst_core_o, busy_o, done_o, res_valid_o,
                 res_ap_o, res_cm_o, res_alarm_o, res_cycles_o}, 0);
    @(negedge clk_i);
    #2 rstn_i = 1'b1;

    $display("[TB] fresh sweep with first- and last-cycle alarms");
    runSweep(8, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
